// File: rtl/adder3_share_ctrl.sv
// Round-robin sequencer sharing a single 3-bit ripple adder among NREQ requesters.
// Each transaction: IDLE grant/capture -> EXEC add -> RESP until owner accepts.

module adder3bit (
  input  logic [2:0] a_i,
  input  logic [2:0] b_i,
  input  logic       cin_i,
  output logic [2:0] sum_o,
  output logic       cout_o
);
  logic [3:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < 3; i++) begin : g_fa
    assign sum_o[i]    = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i+1]  = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[3];
endmodule

module adder3_share_ctrl #(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [3*NREQ-1:0] req_a,
  input  logic [3*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [2:0]        rsp_sum,
  output logic              rsp_cout,
  output logic              busy
);
  localparam int PW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] owner_q;
  logic [2:0]    a_q, b_q;
  logic [2:0]    sum_q;
  logic          cout_q;

  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [2:0]    add_sum;
  logic          add_cout;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && req_valid[(int'(ptr_q) + k) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = PW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_found) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_ready[owner_q]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  adder3bit u_add (
    .a_i   (a_q),
    .b_i   (b_q),
    .cin_i (1'b0),
    .sum_o (add_sum),
    .cout_o(add_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && win_found) begin
        a_q     <= req_a[3*int'(win_idx) +: 3];
        b_q     <= req_b[3*int'(win_idx) +: 3];
        owner_q <= win_idx;
      end
      if (state_q == S_EXEC) begin
        sum_q  <= add_sum;
        cout_q <= add_cout;
      end
      if (state_q == S_RESP && rsp_ready[owner_q]) begin
        ptr_q <= (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
      end
    end
  end

  // Grant is combinational so the handshake completes in the request cycle.
  assign req_ready = (rst_n && state_q == S_IDLE && win_found) ?
                     (NREQ'(1) << win_idx) : '0;
  assign rsp_valid = (state_q == S_RESP) ? (NREQ'(1) << owner_q) : '0;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_adder3_share_ctrl.sv
// Scoreboard bench for adder3_share_ctrl: transaction-level round-robin model
// predicts grants and results; a monitor checks responses as they are presented.

module tb_adder3_share_ctrl;
  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [3*NREQ-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [2:0]        rsp_sum;
  logic              rsp_cout;
  logic              busy;

  adder3_share_ctrl #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int owner; int sum; int cout; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  // Transaction-level model: who is being served, how long ago, and the pointer.
  bit m_busy = 0;
  int m_owner = 0;
  int m_age = 0;
  int m_ptr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int rr_winner(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [3*NREQ-1:0] rnd_ops();
    return (3*NREQ)'($urandom);
  endfunction

  task automatic step(input logic [NREQ-1:0] v, input logic [3*NREQ-1:0] a,
                      input logic [3*NREQ-1:0] b, input logic [NREQ-1:0] rr,
                      input bit rst, output bit granted);
    int w, s;
    logic [NREQ-1:0] exp_rdy, exp_rv;
    exp_t e;
    @(negedge clk);
    req_valid = v; req_a = a; req_b = b; rsp_ready = rr; rst_n = rst;
    #1;
    granted = 0;
    w = m_busy ? -1 : rr_winner(v, m_ptr);
    exp_rdy = (rst && w >= 0) ? oh(w) : '0;
    exp_rv  = (m_busy && m_age >= 1) ? oh(m_owner) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("busy", 32'(busy), 32'(m_busy));
    if (!rst) begin
      m_busy = 0; m_ptr = 0; m_age = 0;
      sb.delete();
    end else if (!m_busy) begin
      if (w >= 0) begin
        s = int'(a[3*w +: 3]) + int'(b[3*w +: 3]);
        e.owner = w; e.sum = s % 8; e.cout = (s > 7) ? 1 : 0;
        sb.push_back(e);
        m_busy = 1; m_owner = w; m_age = 0; granted = 1;
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (rr[m_owner]) begin
      m_busy = 0;
      m_ptr = (m_owner + 1) % NREQ;
    end
  endtask

  task automatic drain();
    bit g;
    for (int i = 0; i < 12 && m_busy; i++) step('0, rnd_ops(), rnd_ops(), '1, 1, g);
    chk("drain_timeout", 32'(m_busy), 32'(0));
  endtask

  task automatic do_txn(input int r, input int a, input int b);
    bit g;
    logic [3*NREQ-1:0] va, vb;
    g = 0;
    for (int i = 0; i < 10 && !g; i++) begin
      va = rnd_ops(); vb = rnd_ops();
      va[3*r +: 3] = 3'(a); vb[3*r +: 3] = 3'(b);
      step(oh(r), va, vb, '1, 1, g);
    end
    chk("grant_timeout", 32'(g), 32'(1));
    drain();
  endtask

  // Monitor: compare every presented response against the scoreboard head.
  initial begin
    int owner;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rsp_valid !== '0) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL rsp_unexpected actual=%0h expected=none", rsp_valid);
        end else begin
          owner = 0;
          for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) owner = i;
          e = sb[0];
          chk("rsp_onehot", 32'($onehot(rsp_valid)), 32'(1));
          chk("rsp_owner", 32'(owner), 32'(e.owner));
          chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
          chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
          if (rsp_ready[owner]) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g;
    int gq[$];
    logic [3*NREQ-1:0] va;
    rst_n = 0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;

    step('1, rnd_ops(), rnd_ops(), '1, 0, g);
    step('1, rnd_ops(), rnd_ops(), '1, 0, g);
    chk("rst_sum", 32'(rsp_sum), 32'(0));
    chk("rst_cout", 32'(rsp_cout), 32'(0));

    // Single transactions, including the wrap case
    do_txn(0, 3, 4);
    do_txn(1, 7, 7);

    // Both requesters continuously valid after reset -> alternating grants
    step('0, '0, '0, '1, 0, g);
    for (int i = 0; i < 12; i++) begin
      step('1, rnd_ops(), rnd_ops(), '1, 1, g);
      for (int k = 0; k < NREQ; k++) if (req_ready[k]) gq.push_back(k);
    end
    chk("rr_count", 32'(gq.size()), 32'(4));
    for (int k = 0; k < 4 && k < gq.size(); k++) chk("rr_order", 32'(gq[k]), 32'(k % 2));
    drain();

    // Owner holds off its response while requester 1 waits
    va = rnd_ops(); va[2:0] = 3'd5;
    g = 0;
    for (int i = 0; i < 6 && !g; i++) begin
      va[5:3] = 3'($urandom);
      step(2'b01, va, {3'($urandom), 3'd2}, '0, 1, g);
    end
    for (int i = 0; i < 6; i++) step(2'b10, rnd_ops(), rnd_ops(), 2'b10, 1, g);
    step(2'b10, rnd_ops(), rnd_ops(), 2'b01, 1, g);
    step(2'b10, rnd_ops(), rnd_ops(), '1, 1, g);
    chk("held_then_grant1", 32'(g), 32'(1));
    drain();

    // Reset during EXEC drops the transaction and restores pointer 0
    do_txn(0, 1, 1);
    g = 0;
    for (int i = 0; i < 4 && !g; i++) step('1, rnd_ops(), rnd_ops(), '1, 1, g);
    step('0, rnd_ops(), rnd_ops(), '1, 0, g);
    step('1, rnd_ops(), rnd_ops(), '1, 1, g);
    chk("post_rst_grant0", 32'(req_ready), 32'(2'b01));
    drain();

    // Exhaustive operand sweep through every requester
    for (int r = 0; r < NREQ; r++)
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < 8; b++)
          do_txn(r, a, b);

    // Randomized traffic with random response back-pressure
    for (int i = 0; i < 400; i++)
      step(NREQ'($urandom), rnd_ops(), rnd_ops(),
           NREQ'($urandom | $urandom), 1, g);
    drain();
    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
